amo_sequencer: RTL and testbench
================================

AMO_SEQUENCER -- requirements
Module: amo_sequencer

Interface
REQ-001 SHALL have one clock and an asynchronous, active-low reset: CLK input 1, rising-edge clock.
REQ-002 SHALL have RST_N input 1, asynchronous active-low reset.
REQ-003 SHALL have START input 1: request to execute one atomic operation; accepted only while BUSY=0.
REQ-004 SHALL have AMO_OP input 5: RISC-V funct5 of the atomic instruction; value 5 marks a non-AMO instruction.
REQ-005 SHALL have OP_32 input 1: 1 = .W (32-bit) operation, 0 = .D (64-bit) operation.
REQ-006 SHALL have ADDR input 64 (effective address) and RS2_DATA input 64 (source operand).
REQ-007 SHALL have FLUSH input 1 (pipeline kill) and RES_CLEAR input 1 (reservation invalidate, from trap or snoop).
REQ-008 SHALL have DC_REQ_VALID, DC_REQ_WE and DC_REQ_WORD outputs, 1 bit each; DC_REQ_ADDR output 64; DC_REQ_WDATA output 64.
REQ-009 SHALL have DC_REQ_READY input 1, DC_RESP_VALID input 1 and DC_RESP_DATA input 64; DC_RESP_VALID acknowledges both reads and writes.
REQ-010 SHALL have BUSY, DONE and ERR outputs, 1 bit each, and RESULT output 64 (value written back to rd).

Function
REQ-011 SHALL implement states IDLE, RD_REQ, RD_WAIT, WR_REQ, WR_WAIT and FIN; BUSY = (state != IDLE).
REQ-012 SHALL latch AMO_OP, OP_32, ADDR and RS2_DATA when START=1 in IDLE, and leave IDLE on the next edge.
REQ-013 SHALL decode the ops as follows: LR=00010, SC=00011, SWAP=00001, ADD=00000, XOR=00100, AND=01100, OR=01000, MIN=10000, MAX=10100, MINU=11000, MAXU=11100; any other value is illegal.
REQ-014 SHALL treat as errors an illegal op, or ADDR misaligned (ADDR[1:0]!=0 when OP_32=1; ADDR[2:0]!=0 when OP_32=0): IDLE->FIN, no cache request, ERR=1, RESULT=0.
REQ-015 SHALL sequence the legal non-SC ops as IDLE->RD_REQ, with LR continuing RD_WAIT->FIN and all other AMOs continuing RD_WAIT->WR_REQ->WR_WAIT->FIN.
REQ-016 SHALL sequence SC as IDLE->WR_REQ when the reservation matches (RESULT=0) and as IDLE->FIN with no access when it does not (RESULT=1).
REQ-017 SHALL assert DC_REQ_VALID only in RD_REQ and WR_REQ, holding ADDR, WE, WORD and WDATA stable until DC_REQ_READY=1; the handshake advances REQ->WAIT.
REQ-018 SHALL advance WAIT->next state on DC_REQ_VALID... on DC_RESP_VALID=1 in a WAIT state; DC_RESP_VALID in any other state SHALL be ignored.
REQ-019 SHALL capture the read data in RD_WAIT; for OP_32=1 the old value = sign-extended DC_RESP_DATA[31:0].
REQ-020 SHALL set RESULT = old value for LR and all AMOs, held from FIN until the next START is accepted.
REQ-021 SHALL compute the write value in WR_REQ from old value and RS2: SWAP=rs2, ADD=wrapping sum, XOR/AND/OR bitwise, MIN/MAX signed compare, MINU/MAXU unsigned compare; for SC the write value = rs2.
REQ-022 SHALL perform 32-bit ops on bits [31:0] only, with the signed compare on bit 31 and DC_REQ_WDATA[63:32]=0.
REQ-023 SHALL have a latency from START to DONE of at least 5 cycles for an AMO, 3 for LR, 3 for SC success, and 1 for SC fail or an error.
REQ-024 SHALL pulse DONE for exactly one cycle in FIN, then return to IDLE; START during FIN is ignored.
REQ-025 SHALL set the reservation (RES_VALID=1, RES_ADDR=ADDR[63:3]) on LR completion; a match is RES_VALID && ADDR[63:3]==RES_ADDR.
REQ-026 SHALL clear the reservation on every SC, pass or fail, and on RES_CLEAR; when RES_CLEAR coincides with an LR completion, the clear wins.
REQ-027 SHALL, when FLUSH=1 in IDLE, refuse START, and when FLUSH=1 in RD_REQ or WR_REQ before the handshake, return to IDLE with no DONE and no reservation change.
REQ-028 SHALL ignore FLUSH after a request has been accepted, completing the sequence so that atomicity is preserved.

Reset
REQ-029 SHALL, while RST_N=0, force the state to IDLE, RES_VALID=0, and all outputs (DC_REQ_*, BUSY, DONE, ERR, RESULT) to 0, including when reset is asserted mid-operation; no request is re-issued after reset.

Verification
REQ-030 SHALL cover AMOADD.D at ADDR=0x1000, mem=5, rs2=3, with READY and RESP on first opportunity -> write 8, RESULT=5, DONE at cycle 5.
REQ-031 SHALL cover AMOMIN.W with mem=0xFFFFFFFF and rs2=1 -> WDATA=0x00000000FFFFFFFF, RESULT=0xFFFFFFFFFFFFFFFF.
REQ-032 SHALL cover LR.D 0x2000 then SC.D 0x2000 -> RESULT=0 with a write issued; a second SC.D 0x2000 -> RESULT=1, no request, DONE after 1 cycle.
REQ-033 SHALL cover LR then RES_CLEAR then SC to the same address -> SC fails with RESULT=1; LR 0x2000 then SC 0x2008 -> fails.
REQ-034 SHALL cover AMO_OP=5 or AMOSWAP.W at ADDR=0x1002 -> ERR=1, RESULT=0, no DC_REQ_VALID.
REQ-035 SHALL cover FLUSH in RD_REQ with READY=0 -> IDLE, no DONE; RST_N low during WR_WAIT -> all outputs 0, BUSY=0.

Source files
------------

// File: rtl/amo_sequencer.sv
`default_nettype none
// amo_sequencer: sequences RISC-V LR/SC/AMO instructions into read-modify-write
// data-cache transactions and tracks the LR reservation. Revision 1.0.
module amo_sequencer (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [4:0]  amo_op,
   input  logic        op_32,
   input  logic [63:0] addr,
   input  logic [63:0] rs2_data,
   input  logic        flush,
   input  logic        res_clear,
   output logic        dc_req_valid,
   output logic        dc_req_we,
   output logic        dc_req_word,
   output logic [63:0] dc_req_addr,
   output logic [63:0] dc_req_wdata,
   input  logic        dc_req_ready,
   input  logic        dc_resp_valid,
   input  logic [63:0] dc_resp_data,
   output logic        busy,
   output logic        done,
   output logic        err,
   output logic [63:0] result
);

   localparam logic [4:0] OP_ADD  = 5'b00000;
   localparam logic [4:0] OP_SWAP = 5'b00001;
   localparam logic [4:0] OP_LR   = 5'b00010;
   localparam logic [4:0] OP_SC   = 5'b00011;
   localparam logic [4:0] OP_XOR  = 5'b00100;
   localparam logic [4:0] OP_OR   = 5'b01000;
   localparam logic [4:0] OP_AND  = 5'b01100;
   localparam logic [4:0] OP_MIN  = 5'b10000;
   localparam logic [4:0] OP_MAX  = 5'b10100;
   localparam logic [4:0] OP_MINU = 5'b11000;
   localparam logic [4:0] OP_MAXU = 5'b11100;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      RD_REQ  = 3'd1,
      RD_WAIT = 3'd2,
      WR_REQ  = 3'd3,
      WR_WAIT = 3'd4,
      FIN     = 3'd5
   } state_t;

   state_t      state;
   state_t      state_nxt;

   logic [4:0]  op_q;
   logic        op32_q;
   logic [63:0] addr_q;
   logic [63:0] rs2_q;
   logic [63:0] old_q;
   logic [63:0] result_q;
   logic        err_q;
   logic        res_valid;
   logic [60:0] res_addr;

   logic        legal;
   logic        misaligned;
   logic        bad;
   logic        is_sc;
   logic        res_match;
   logic        accept;
   logic [63:0] old_val;
   logic [63:0] wdata;
   logic [63:0] wd64;
   logic [31:0] wd32;

   always_comb begin
      legal = 1'b0;
      case (amo_op)
         OP_ADD, OP_SWAP, OP_LR, OP_SC, OP_XOR, OP_OR, OP_AND,
         OP_MIN, OP_MAX, OP_MINU, OP_MAXU: legal = 1'b1;
         default:                          legal = 1'b0;
      endcase
   end

   assign misaligned = op_32 ? (addr[1:0] != 2'b00) : (addr[2:0] != 3'b000);
   assign bad        = !legal || misaligned;
   assign is_sc      = (amo_op == OP_SC);
   assign res_match  = res_valid && (addr[63:3] == res_addr);
   assign accept     = (state == IDLE) && start && !flush;
   assign old_val    = op32_q ? {{32{dc_resp_data[31]}}, dc_resp_data[31:0]} : dc_resp_data;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // A request that has been handshaken is never abandoned, so flush only
   // takes effect while the cache is still refusing it.
   always_comb begin
      state_nxt    = state;
      busy         = (state != IDLE);
      done         = 1'b0;
      dc_req_valid = 1'b0;
      dc_req_we    = 1'b0;
      case (state)
         IDLE: begin
            if (accept) begin
               if (bad) begin
                  state_nxt = FIN;
               end else if (is_sc) begin
                  state_nxt = res_match ? WR_REQ : FIN;
               end else begin
                  state_nxt = RD_REQ;
               end
            end
         end
         RD_REQ: begin
            dc_req_valid = 1'b1;
            if (dc_req_ready) begin
               state_nxt = RD_WAIT;
            end else if (flush) begin
               state_nxt = IDLE;
            end
         end
         RD_WAIT: begin
            if (dc_resp_valid) begin
               state_nxt = (op_q == OP_LR) ? FIN : WR_REQ;
            end
         end
         WR_REQ: begin
            dc_req_valid = 1'b1;
            dc_req_we    = 1'b1;
            if (dc_req_ready) begin
               state_nxt = WR_WAIT;
            end else if (flush) begin
               state_nxt = IDLE;
            end
         end
         WR_WAIT: begin
            if (dc_resp_valid) begin
               state_nxt = FIN;
            end
         end
         FIN: begin
            done      = 1'b1;
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // Both lanes are computed; .W results are zero-extended into the write bus.
   always_comb begin
      wd64 = rs2_q;
      wd32 = rs2_q[31:0];
      case (op_q)
         OP_ADD: begin
            wd64 = old_q + rs2_q;
            wd32 = old_q[31:0] + rs2_q[31:0];
         end
         OP_XOR: begin
            wd64 = old_q ^ rs2_q;
            wd32 = old_q[31:0] ^ rs2_q[31:0];
         end
         OP_AND: begin
            wd64 = old_q & rs2_q;
            wd32 = old_q[31:0] & rs2_q[31:0];
         end
         OP_OR: begin
            wd64 = old_q | rs2_q;
            wd32 = old_q[31:0] | rs2_q[31:0];
         end
         OP_MIN: begin
            wd64 = ($signed(old_q) < $signed(rs2_q)) ? old_q : rs2_q;
            wd32 = ($signed(old_q[31:0]) < $signed(rs2_q[31:0])) ? old_q[31:0] : rs2_q[31:0];
         end
         OP_MAX: begin
            wd64 = ($signed(old_q) > $signed(rs2_q)) ? old_q : rs2_q;
            wd32 = ($signed(old_q[31:0]) > $signed(rs2_q[31:0])) ? old_q[31:0] : rs2_q[31:0];
         end
         OP_MINU: begin
            wd64 = (old_q < rs2_q) ? old_q : rs2_q;
            wd32 = (old_q[31:0] < rs2_q[31:0]) ? old_q[31:0] : rs2_q[31:0];
         end
         OP_MAXU: begin
            wd64 = (old_q > rs2_q) ? old_q : rs2_q;
            wd32 = (old_q[31:0] > rs2_q[31:0]) ? old_q[31:0] : rs2_q[31:0];
         end
         default: begin
            wd64 = rs2_q;
            wd32 = rs2_q[31:0];
         end
      endcase
      wdata = op32_q ? {32'h0, wd32} : wd64;
   end

   assign dc_req_addr  = dc_req_valid ? addr_q : 64'h0;
   assign dc_req_word  = dc_req_valid & op32_q;
   assign dc_req_wdata = dc_req_we ? wdata : 64'h0;
   assign err          = err_q;
   assign result       = result_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op_q     <= 5'h0;
         op32_q   <= 1'b0;
         addr_q   <= 64'h0;
         rs2_q    <= 64'h0;
         old_q    <= 64'h0;
         result_q <= 64'h0;
         err_q    <= 1'b0;
      end else begin
         if (accept) begin
            op_q     <= amo_op;
            op32_q   <= op_32;
            addr_q   <= addr;
            rs2_q    <= rs2_data;
            result_q <= 64'h0;
            err_q    <= bad;
            if (!bad && is_sc && !res_match) begin
               result_q <= 64'h1;
            end
         end
         if ((state == RD_WAIT) && dc_resp_valid) begin
            old_q <= old_val;
            if (op_q == OP_LR) begin
               result_q <= old_val;
            end
         end
         if ((state == WR_WAIT) && dc_resp_valid) begin
            result_q <= (op_q == OP_SC) ? 64'h0 : old_q;
         end
      end
   end

   // An SC consumes the reservation once its decision is final: on a failed
   // match at issue, or when its store is accepted by the cache.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         res_valid <= 1'b0;
         res_addr  <= 61'h0;
      end else if (res_clear) begin
         res_valid <= 1'b0;
      end else if ((state == RD_WAIT) && dc_resp_valid && (op_q == OP_LR)) begin
         res_valid <= 1'b1;
         res_addr  <= addr_q[63:3];
      end else if (accept && !bad && is_sc && !res_match) begin
         res_valid <= 1'b0;
      end else if ((state == WR_REQ) && dc_req_ready && (op_q == OP_SC)) begin
         res_valid <= 1'b0;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_amo_sequencer.sv
`default_nettype none
// tb_amo_sequencer: directed-vector bench for amo_sequencer with a
// first-opportunity cache responder driven from the stimulus sequence.
module tb_amo_sequencer;

   localparam logic [4:0] OP_ADD  = 5'b00000;
   localparam logic [4:0] OP_SWAP = 5'b00001;
   localparam logic [4:0] OP_LR   = 5'b00010;
   localparam logic [4:0] OP_SC   = 5'b00011;
   localparam logic [4:0] OP_XOR  = 5'b00100;
   localparam logic [4:0] OP_MIN  = 5'b10000;
   localparam logic [4:0] OP_MAX  = 5'b10100;
   localparam logic [4:0] OP_MAXU = 5'b11100;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic [4:0]  amo_op = 5'h0;
   logic        op_32 = 1'b0;
   logic [63:0] addr = 64'h0;
   logic [63:0] rs2_data = 64'h0;
   logic        flush = 1'b0;
   logic        res_clear = 1'b0;
   logic        dc_req_valid;
   logic        dc_req_we;
   logic        dc_req_word;
   logic [63:0] dc_req_addr;
   logic [63:0] dc_req_wdata;
   logic        dc_req_ready = 1'b1;
   logic        dc_resp_valid = 1'b0;
   logic [63:0] dc_resp_data = 64'h0;
   logic        busy;
   logic        done;
   logic        err;
   logic [63:0] result;

   int          vectors = 0;
   int          miscompares = 0;
   int          req_cnt = 0;
   int          done_cnt = 0;
   int          lat;
   int          snap;
   int          snap_done;
   logic [63:0] last_wdata;
   logic [63:0] last_waddr;

   amo_sequencer dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .start        (start),
      .amo_op       (amo_op),
      .op_32        (op_32),
      .addr         (addr),
      .rs2_data     (rs2_data),
      .flush        (flush),
      .res_clear    (res_clear),
      .dc_req_valid (dc_req_valid),
      .dc_req_we    (dc_req_we),
      .dc_req_word  (dc_req_word),
      .dc_req_addr  (dc_req_addr),
      .dc_req_wdata (dc_req_wdata),
      .dc_req_ready (dc_req_ready),
      .dc_resp_valid(dc_resp_valid),
      .dc_resp_data (dc_resp_data),
      .busy         (busy),
      .done         (done),
      .err          (err),
      .result       (result)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (dc_req_valid) req_cnt <= req_cnt + 1;
      if (done) done_cnt <= done_cnt + 1;
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Issues one instruction and answers every request on first opportunity.
   // lat = posedges from the accepting edge until DONE is seen (99 on timeout).
   task automatic do_op(input logic [4:0] op, input logic w, input logic [63:0] a,
                        input logic [63:0] rs2, input logic [63:0] rdata, output int l);
      bit pend;
      pend = 1'b0;
      l = 99;
      last_wdata = 64'h0;
      last_waddr = 64'h0;
      @(negedge clk);
      start = 1'b1; amo_op = op; op_32 = w; addr = a; rs2_data = rs2;
      for (int i = 1; i <= 20; i++) begin
         @(negedge clk);
         start = 1'b0;
         dc_resp_valid = 1'b0;
         if (done) begin
            l = i;
            break;
         end
         if (pend) begin
            dc_resp_valid = 1'b1;
            dc_resp_data  = rdata;
            pend = 1'b0;
         end else if (dc_req_valid) begin
            if (dc_req_we) begin
               last_wdata = dc_req_wdata;
               last_waddr = dc_req_addr;
            end
            pend = 1'b1;
         end
      end
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      repeat (3) @(negedge clk);
      check("rst_busy", {63'h0, busy}, 64'h0);
      check("rst_done", {63'h0, done}, 64'h0);
      check("rst_valid", {63'h0, dc_req_valid}, 64'h0);
      check("rst_result", result, 64'h0);
      rst_n = 1'b1;
      @(negedge clk);

      // AMOADD.D
      do_op(OP_ADD, 1'b0, 64'h1000, 64'd3, 64'd5, lat);
      check("add_lat", 64'(lat), 64'd5);
      check("add_wdata", last_wdata, 64'd8);
      check("add_waddr", last_waddr, 64'h1000);
      check("add_result", result, 64'd5);
      check("add_err", {63'h0, err}, 64'h0);

      // AMOMIN.W, upper read bits must be ignored
      do_op(OP_MIN, 1'b1, 64'h1004, 64'h0000_0000_0000_0001, 64'hDEAD_BEEF_FFFF_FFFF, lat);
      check("minw_lat", 64'(lat), 64'd5);
      check("minw_wdata", last_wdata, 64'h0000_0000_FFFF_FFFF);
      check("minw_result", result, 64'hFFFF_FFFF_FFFF_FFFF);

      // AMOXOR.W with junk in rs2 upper half
      do_op(OP_XOR, 1'b1, 64'h1008, 64'h1234_5678_FFFF_0000, 64'h0000_0000_0F0F_0F0F, lat);
      check("xorw_wdata", last_wdata, 64'h0000_0000_F0F0_0F0F);
      check("xorw_result", result, 64'h0000_0000_0F0F_0F0F);

      // signed vs unsigned max on the same operands
      do_op(OP_MAXU, 1'b0, 64'h1010, 64'd1, 64'h8000_0000_0000_0000, lat);
      check("maxu_wdata", last_wdata, 64'h8000_0000_0000_0000);
      do_op(OP_MAX, 1'b0, 64'h1010, 64'd1, 64'h8000_0000_0000_0000, lat);
      check("max_wdata", last_wdata, 64'd1);
      check("max_result", result, 64'h8000_0000_0000_0000);

      // LR / SC pass / SC fail
      do_op(OP_LR, 1'b0, 64'h2000, 64'h0, 64'h55, lat);
      check("lr_lat", 64'(lat), 64'd3);
      check("lr_result", result, 64'h55);
      do_op(OP_SC, 1'b0, 64'h2000, 64'hAB, 64'h0, lat);
      check("sc_lat", 64'(lat), 64'd3);
      check("sc_result", result, 64'h0);
      check("sc_wdata", last_wdata, 64'hAB);
      check("sc_waddr", last_waddr, 64'h2000);
      snap = req_cnt;
      do_op(OP_SC, 1'b0, 64'h2000, 64'hCD, 64'h0, lat);
      check("sc2_lat", 64'(lat), 64'd1);
      check("sc2_result", result, 64'h1);
      check("sc2_noreq", 64'(req_cnt - snap), 64'h0);

      // LR, RES_CLEAR, SC
      do_op(OP_LR, 1'b0, 64'h2000, 64'h0, 64'h77, lat);
      @(negedge clk);
      res_clear = 1'b1;
      @(negedge clk);
      res_clear = 1'b0;
      do_op(OP_SC, 1'b0, 64'h2000, 64'h1, 64'h0, lat);
      check("clr_sc_result", result, 64'h1);
      check("clr_sc_lat", 64'(lat), 64'd1);

      // LR then SC to a different doubleword
      do_op(OP_LR, 1'b0, 64'h2000, 64'h0, 64'h77, lat);
      do_op(OP_SC, 1'b0, 64'h2008, 64'h1, 64'h0, lat);
      check("addr_sc_result", result, 64'h1);

      // illegal op and misaligned address
      snap = req_cnt;
      do_op(5'd5, 1'b0, 64'h1000, 64'h1, 64'h0, lat);
      check("ill_lat", 64'(lat), 64'd1);
      check("ill_err", {63'h0, err}, 64'h1);
      check("ill_result", result, 64'h0);
      do_op(OP_SWAP, 1'b1, 64'h1002, 64'h1, 64'h0, lat);
      check("mis_err", {63'h0, err}, 64'h1);
      check("mis_result", result, 64'h0);
      check("err_noreq", 64'(req_cnt - snap), 64'h0);

      // FLUSH refuses START in IDLE
      @(negedge clk);
      flush = 1'b1; start = 1'b1; amo_op = OP_ADD; op_32 = 1'b0; addr = 64'h1000;
      @(negedge clk);
      start = 1'b0; flush = 1'b0;
      check("flush_idle_busy", {63'h0, busy}, 64'h0);

      // FLUSH in RD_REQ with READY low
      snap_done = done_cnt;
      dc_req_ready = 1'b0;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("fl_rdreq_valid", {63'h0, dc_req_valid}, 64'h1);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      dc_req_ready = 1'b1;
      check("fl_busy", {63'h0, busy}, 64'h0);
      @(negedge clk);
      check("fl_nodone", 64'(done_cnt - snap_done), 64'h0);

      // reset asserted in WR_WAIT
      start = 1'b1; amo_op = OP_ADD; op_32 = 1'b0; addr = 64'h1000; rs2_data = 64'd3;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      dc_resp_valid = 1'b1; dc_resp_data = 64'd5;
      @(negedge clk);
      dc_resp_valid = 1'b0;
      check("rw_wrreq_we", {63'h0, dc_req_we}, 64'h1);
      @(negedge clk);
      check("rw_wrwait_busy", {63'h0, busy}, 64'h1);
      rst_n = 1'b0;
      #1;
      check("rw_busy", {63'h0, busy}, 64'h0);
      check("rw_valid", {63'h0, dc_req_valid}, 64'h0);
      check("rw_we", {63'h0, dc_req_we}, 64'h0);
      check("rw_word", {63'h0, dc_req_word}, 64'h0);
      check("rw_addr", dc_req_addr, 64'h0);
      check("rw_wdata", dc_req_wdata, 64'h0);
      check("rw_done", {63'h0, done}, 64'h0);
      check("rw_err", {63'h0, err}, 64'h0);
      check("rw_result", result, 64'h0);
      @(negedge clk);
      rst_n = 1'b1;
      snap = req_cnt;
      dc_resp_valid = 1'b1;
      repeat (3) @(negedge clk);
      dc_resp_valid = 1'b0;
      check("rw_noreissue", 64'(req_cnt - snap), 64'h0);
      check("rw_idle", {63'h0, busy}, 64'h0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
`default_nettype wire
